// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle DIV/DIVU unit for the EX stage. It uses a restoring
//   shift-subtract algorithm and produces one quotient bit per clock. The
//   result is {HI, LO} = {remainder, quotient}.
//
//   Handshake: EX holds start_i high for the whole operation. The unit
//   accepts the request on the first edge where start_i=1 and annul_i=0.
//   It raises ready_o when result_o is valid, then holds both until
//   start_i drops. stallreq_o freezes the pipeline from the accept cycle
//   until ready_o rises.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous, active-high reset
//   signed_div_i  1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       divide request, held for the whole operation
//   annul_i       abort the operation in progress
//   result_o      [2*DATA_W-1:DATA_W] remainder (HI), [DATA_W-1:0] quotient (LO)
//   ready_o       result_o valid
//   stallreq_o    pipeline stall request (combinational)
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;       // partial remainder
  logic [DATA_W-1:0]   quo_q, quo_d;       // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]   dvs_q, dvs_d;       // latched |divisor|
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W:0]     partial;
  logic [DATA_W:0]     trial;
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic                sign_a;
  logic                sign_b;

  // The partial remainder stays below the divisor. The shifted value
  // therefore fits in DATA_W+1 bits, and bit DATA_W of the trial difference
  // is a reliable borrow (negative) flag.
  assign partial = {rem_q, quo_q[DATA_W-1]};
  assign trial   = partial - {1'b0, dvs_q};

  assign sign_a = signed_div_i & opdata1_i[DATA_W-1];
  assign sign_b = signed_div_i & opdata2_i[DATA_W-1];
  // Negating the most negative value wraps to itself. Read as unsigned,
  // that is still the correct magnitude.
  assign abs_a  = sign_a ? -opdata1_i : opdata1_i;
  assign abs_b  = sign_b ? -opdata2_i : opdata2_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      S_FREE: begin
        if (start_i && !annul_i) begin
          rem_d     = '0;
          quo_d     = abs_a;
          dvs_d     = abs_b;
          neg_quo_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          cnt_d     = '0;
          state_d   = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end

      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          rem_d   = '0;
          quo_d   = '0;
          state_d = S_END;
        end
      end

      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != LAST_CNT) begin
          cnt_d = cnt_q + 1'b1;
          if (!trial[DATA_W]) begin
            rem_d = trial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = partial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          // Apply the signs: the quotient is negative when the operand signs
          // differ, and the remainder follows the dividend's sign.
          quo_d   = neg_quo_q ? -quo_q : quo_q;
          rem_d   = neg_rem_q ? -rem_q : rem_q;
          state_d = S_END;
        end
      end

      S_END: begin
        // annul_i is ignored here. The result is already committed to
        // EX/MEM timing.
        if (!start_i) begin
          state_d  = S_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (!ready_q) begin
          result_d = {rem_q, quo_q};
          ready_d  = 1'b1;
        end
      end

      default: state_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~annul_i & ~ready_q;

endmodule
